// File: rtl/branch_resolve_unit.sv
// Branch resolve unit.
// Evaluates an 8-way branch condition on two forwarded operands and registers
// the outcome in a one-entry valid/stall result stage. Keeps a PC-indexed table
// of 2-bit saturating predictor counters that is trained by retiring results.
// Also counts resolved branches and mispredicts.
module branch_resolve_unit #(
  parameter int WIDTH    = 32,
  parameter int IDX_BITS = 6,
  parameter int PC_W     = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [PC_W-1:0]   lookup_pc,
  output logic              lookup_taken,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_cond,
  input  logic [WIDTH-1:0]  req_a,
  input  logic [WIDTH-1:0]  req_b,
  input  logic [PC_W-1:0]   req_pc,
  input  logic              req_pred,
  input  logic              stall,
  input  logic              flush,
  output logic              res_valid,
  output logic              res_taken,
  output logic              res_mispredict,
  output logic [PC_W-1:0]   res_pc,
  output logic [31:0]       br_count,
  output logic [31:0]       mispred_count
);

  localparam int DEPTH = 2 ** IDX_BITS;

  typedef enum logic [2:0] {
    COND_BEQ  = 3'd0,
    COND_BNE  = 3'd1,
    COND_BLEZ = 3'd2,
    COND_BGEZ = 3'd3,
    COND_BGTZ = 3'd4,
    COND_BLTZ = 3'd5,
    COND_BLT  = 3'd6,
    COND_BLTU = 3'd7
  } cond_e;

  // Counters power up weakly not taken.
  localparam logic [1:0] CTR_INIT = 2'b01;

  // Resolve the branch condition. Codes 2-5 compare a against zero only.
  function automatic logic eval_cond(input logic [2:0] cond,
                                     input logic [WIDTH-1:0] a,
                                     input logic [WIDTH-1:0] b);
    logic a_zero;
    logic a_neg;
    logic taken;
    a_zero = (a == '0);
    a_neg  = a[WIDTH-1];
    case (cond_e'(cond))
      COND_BEQ:  taken = (a == b);
      COND_BNE:  taken = (a != b);
      COND_BLEZ: taken = a_neg | a_zero;
      COND_BGEZ: taken = !a_neg;
      COND_BGTZ: taken = !a_neg & !a_zero;
      COND_BLTZ: taken = a_neg;
      COND_BLT:  taken = ($signed(a) < $signed(b));
      COND_BLTU: taken = (a < b);
      default:   taken = 1'b0;
    endcase
    return taken;
  endfunction

  logic [1:0]          ctr [DEPTH];
  logic [IDX_BITS-1:0] lookup_idx;
  logic [IDX_BITS-1:0] res_idx;
  logic                req_taken;
  logic                accept;
  logic                retire;

  // Word-offset and upper PC bits do not take part in indexing.
  logic unused_lookup_bits;
  assign unused_lookup_bits = ^{lookup_pc[PC_W-1:IDX_BITS+2], lookup_pc[1:0]};

  assign lookup_idx = lookup_pc[IDX_BITS+1:2];
  assign res_idx    = res_pc[IDX_BITS+1:2];
  assign req_taken  = eval_cond(req_cond, req_a, req_b);

  // The stage can take a request when empty, draining, or being flushed.
  assign req_ready = !res_valid | !stall | flush;
  assign accept    = req_valid & req_ready;
  assign retire    = res_valid & !stall & !flush;

  // Reading the register array before the edge gives the pre-update value on
  // a lookup/update collision.
  assign lookup_taken = ctr[lookup_idx][1];

  // Result stage: load on accept, hold while stalled, otherwise drain.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      res_valid      <= 1'b0;
      res_taken      <= 1'b0;
      res_mispredict <= 1'b0;
      res_pc         <= '0;
    end else if (accept) begin
      res_valid      <= 1'b1;
      res_taken      <= req_taken;
      res_mispredict <= (req_taken != req_pred);
      res_pc         <= req_pc;
    end else if (flush || !stall) begin
      // Payload keeps its last value; only occupancy drops.
      res_valid      <= 1'b0;
    end
  end

  // Predictor training: only a retiring result moves its counter.
  // NOTE: the table is small and must read weakly-not-taken straight out of
  // reset, so every entry is reset rather than mapped onto a RAM macro.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        ctr[i] <= CTR_INIT;
      end
    end else if (retire) begin
      if (res_taken) begin
        if (ctr[res_idx] != 2'b11) ctr[res_idx] <= ctr[res_idx] + 2'd1;
      end else begin
        if (ctr[res_idx] != 2'b00) ctr[res_idx] <= ctr[res_idx] - 2'd1;
      end
    end
  end

  // Performance counters advance on retire and wrap naturally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      br_count      <= '0;
      mispred_count <= '0;
    end else if (retire) begin
      br_count <= br_count + 32'd1;
      if (res_mispredict) mispred_count <= mispred_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: a table of condition vectors applied
// back to back, plus hand-written stall, flush, saturation and reset sequences.
module tb_branch_resolve_unit;

  logic        clk;
  logic        reset_n;
  logic [31:0] lookup_pc;
  logic        lookup_taken;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_cond;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [31:0] req_pc;
  logic        req_pred;
  logic        stall;
  logic        flush;
  logic        res_valid;
  logic        res_taken;
  logic        res_mispredict;
  logic [31:0] res_pc;
  logic [31:0] br_count;
  logic [31:0] mispred_count;

  int total = 0;
  int bad   = 0;
  int br_exp  = 0;
  int mis_exp = 0;

  branch_resolve_unit #(.WIDTH(32), .IDX_BITS(6), .PC_W(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .lookup_pc(lookup_pc), .lookup_taken(lookup_taken),
    .req_valid(req_valid), .req_ready(req_ready), .req_cond(req_cond),
    .req_a(req_a), .req_b(req_b), .req_pc(req_pc), .req_pred(req_pred),
    .stall(stall), .flush(flush),
    .res_valid(res_valid), .res_taken(res_taken), .res_mispredict(res_mispredict),
    .res_pc(res_pc), .br_count(br_count), .mispred_count(mispred_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  cond;
    logic [31:0] a;
    logic [31:0] b;
    logic        pred;
    logic        exp_taken;
    logic        exp_mis;
  } vec_t;

  localparam int NVEC = 15;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] pc, input logic pred);
    req_valid = 1'b1;
    req_cond  = c;
    req_a     = a;
    req_b     = b;
    req_pc    = pc;
    req_pred  = pred;
  endtask

  initial begin
    int ones;
    logic t5_taken [9];
    logic t5_pre   [9];
    logic t5_post  [9];

    //            cond  a             b             pred taken mis
    vecs[0]  = '{3'd5, 32'h8000_0000, 32'h0,        1'b0, 1'b1, 1'b1}; // BLTZ min
    vecs[1]  = '{3'd3, 32'h8000_0000, 32'h0,        1'b0, 1'b0, 1'b0}; // BGEZ min
    vecs[2]  = '{3'd2, 32'h8000_0000, 32'h0,        1'b1, 1'b1, 1'b0}; // BLEZ min
    vecs[3]  = '{3'd2, 32'h0,         32'h0,        1'b0, 1'b1, 1'b1}; // BLEZ 0
    vecs[4]  = '{3'd3, 32'h0,         32'h0,        1'b1, 1'b1, 1'b0}; // BGEZ 0
    vecs[5]  = '{3'd4, 32'h0,         32'h0,        1'b1, 1'b0, 1'b1}; // BGTZ 0
    vecs[6]  = '{3'd5, 32'h0,         32'h0,        1'b0, 1'b0, 1'b0}; // BLTZ 0
    vecs[7]  = '{3'd6, 32'hFFFF_FFFF, 32'h1,        1'b0, 1'b1, 1'b1}; // BLT -1<1
    vecs[8]  = '{3'd7, 32'hFFFF_FFFF, 32'h1,        1'b1, 1'b0, 1'b1}; // BLTU
    vecs[9]  = '{3'd0, 32'h5,         32'h6,        1'b0, 1'b0, 1'b0}; // BEQ ne
    vecs[10] = '{3'd1, 32'h5,         32'h6,        1'b0, 1'b1, 1'b1}; // BNE ne
    vecs[11] = '{3'd4, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 1'b1, 1'b0}; // BGTZ max, b ignored
    vecs[12] = '{3'd5, 32'h1,         32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0}; // BLTZ 1, b ignored
    vecs[13] = '{3'd6, 32'h1,         32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0}; // BLT 1<-1
    vecs[14] = '{3'd7, 32'h1,         32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0}; // BLTU 1<max

    // Test 5 schedule on PC 0x508 (index 2): counter 01 ->10->11->11->11
    // ->10->01->00->00 ->01. Lookup bit before and after each retire.
    t5_taken = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    t5_pre   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    t5_post  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    reset_n   = 1'b0;
    lookup_pc = 32'h104;
    req_valid = 1'b0;
    req_cond  = 3'd0;
    req_a     = '0;
    req_b     = '0;
    req_pc    = '0;
    req_pred  = 1'b0;
    stall     = 1'b0;
    flush     = 1'b0;

    #12;
    check("rst_res_valid", res_valid, 0);
    check("rst_br_count", br_count, 0);
    check("rst_mispred_count", mispred_count, 0);
    check("rst_lookup", lookup_taken, 0);
    check("rst_req_ready", req_ready, 1);
    @(negedge clk);
    reset_n = 1'b1;

    // ---- Test 1: BEQ 5==5 predicted not taken ----
    @(negedge clk);
    drive_req(3'd0, 32'h5, 32'h5, 32'h104, 1'b0);
    step();
    req_valid = 1'b0;
    check("t1_valid", res_valid, 1);
    check("t1_taken", res_taken, 1);
    check("t1_mis", res_mispredict, 1);
    check("t1_pc", res_pc, 32'h104);
    check("t1_lookup_pre", lookup_taken, 0);
    step();
    br_exp = 1; mis_exp = 1;
    check("t1_valid_drain", res_valid, 0);
    check("t1_br", br_count, br_exp);
    check("t1_mis_cnt", mispred_count, mis_exp);
    check("t1_lookup_post", lookup_taken, 1);

    // ---- Test 2: condition table, back to back ----
    for (int i = 0; i < NVEC; i++) begin
      drive_req(vecs[i].cond, vecs[i].a, vecs[i].b, 32'h200, vecs[i].pred);
      step();
      if (i > 0) begin
        br_exp++;
        if (vecs[i-1].exp_mis) mis_exp++;
      end
      check($sformatf("t2_valid_%0d", i), res_valid, 1);
      check($sformatf("t2_taken_%0d", i), res_taken, vecs[i].exp_taken);
      check($sformatf("t2_mis_%0d", i), res_mispredict, vecs[i].exp_mis);
      check($sformatf("t2_br_%0d", i), br_count, br_exp);
    end
    req_valid = 1'b0;
    step();
    br_exp++;
    if (vecs[NVEC-1].exp_mis) mis_exp++;
    check("t2_br_final", br_count, br_exp);
    check("t2_mis_final", mispred_count, mis_exp);
    check("t2_drain", res_valid, 0);

    // ---- Test 3: stall for 3 cycles with a pending request ----
    drive_req(3'd1, 32'h1, 32'h2, 32'h300, 1'b1); // taken, predicted taken
    step();
    drive_req(3'd0, 32'h3, 32'h3, 32'h304, 1'b0); // taken, mispredicted
    stall = 1'b1;
    #1;
    check("t3_ready_stalled", req_ready, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("t3_hold_valid_%0d", i), res_valid, 1);
      check($sformatf("t3_hold_pc_%0d", i), res_pc, 32'h300);
      check($sformatf("t3_hold_taken_%0d", i), res_taken, 1);
      check($sformatf("t3_hold_mis_%0d", i), res_mispredict, 0);
      check($sformatf("t3_hold_br_%0d", i), br_count, br_exp);
      check($sformatf("t3_hold_ready_%0d", i), req_ready, 0);
    end
    stall = 1'b0;
    #1;
    check("t3_ready_release", req_ready, 1);
    step();
    br_exp++;
    check("t3_b2b_valid", res_valid, 1);
    check("t3_b2b_pc", res_pc, 32'h304);
    check("t3_b2b_mis", res_mispredict, 1);
    check("t3_b2b_br", br_count, br_exp);
    req_valid = 1'b0;
    step();
    br_exp++; mis_exp++;
    check("t3_br_final", br_count, br_exp);
    check("t3_mis_final", mispred_count, mis_exp);

    // ---- Test 4: flush a held result while a new request arrives ----
    drive_req(3'd0, 32'h1, 32'h1, 32'h400, 1'b1);
    step();
    req_valid = 1'b0;
    stall = 1'b1;
    step();
    check("t4_held", res_pc, 32'h400);
    drive_req(3'd1, 32'h1, 32'h1, 32'h404, 1'b1); // not taken, mispredicted
    flush = 1'b1;
    #1;
    check("t4_ready_flush", req_ready, 1);
    step();
    flush = 1'b0;
    stall = 1'b0;
    req_valid = 1'b0;
    check("t4_new_valid", res_valid, 1);
    check("t4_new_pc", res_pc, 32'h404);
    check("t4_new_taken", res_taken, 0);
    check("t4_br_noupd", br_count, br_exp);
    check("t4_mis_noupd", mispred_count, mis_exp);
    step();
    br_exp++; mis_exp++;
    check("t4_br_final", br_count, br_exp);
    check("t4_mis_final", mispred_count, mis_exp);

    // ---- Test 5: saturation in both directions, collision reads old value ----
    lookup_pc = 32'h508;
    for (int i = 0; i < 9; i++) begin
      drive_req(t5_taken[i] ? 3'd0 : 3'd1, 32'h7, 32'h7, 32'h508, 1'b1);
      step();
      req_valid = 1'b0;
      #1;
      check($sformatf("t5_pre_%0d", i), lookup_taken, t5_pre[i]);
      step();
      br_exp++;
      if (!t5_taken[i]) mis_exp++;
      check($sformatf("t5_post_%0d", i), lookup_taken, t5_post[i]);
    end
    check("t5_br", br_count, br_exp);
    check("t5_mis", mispred_count, mis_exp);

    // ---- Test 6: asynchronous reset while a result is held ----
    lookup_pc = 32'h104;
    #1;
    check("t6_lookup_before", lookup_taken, 1);
    drive_req(3'd0, 32'h9, 32'h9, 32'h608, 1'b0);
    step();
    req_valid = 1'b0;
    stall = 1'b1;
    step();
    check("t6_held_valid", res_valid, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_valid", res_valid, 0);
    check("t6_taken", res_taken, 0);
    check("t6_mis", res_mispredict, 0);
    check("t6_pc", res_pc, 0);
    check("t6_br", br_count, 0);
    check("t6_mis_cnt", mispred_count, 0);
    ones = 0;
    for (int i = 0; i < 64; i++) begin
      lookup_pc = 32'(i) << 2;
      #1;
      if (lookup_taken !== 1'b0) ones++;
    end
    check("t6_lookup_all", ones, 0);
    stall = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    step();
    check("t6_after_valid", res_valid, 0);
    check("t6_after_br", br_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
